// File: rtl/match_logger_pkg.sv
// Shared definitions for the match event logger: default sizes, the logged
// event record and the saturating increment used by both counters.
// Build option: define MEL_DROP_CNT_EN to add the dropped-match counter.
package match_logger_pkg;

   localparam int TS_W_DEF  = 16;
   localparam int DEPTH_DEF = 4;
   localparam int CNT_W_DEF = 16;

   // One logged event: the cycle timestamp of the match.
   typedef struct packed {
      logic [TS_W_DEF-1:0] ts;
   } evt_rec_t;

   // Increment v, holding at max_v once reached (max_v is the all-ones value
   // of the caller's counter width).
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
      return (v >= max_v) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/match_event_logger_if.sv
// Valid/ready event stream carrying the timestamp of the head event.
// The logger drives it through the master modport, the consumer through slave.
interface match_event_logger_if
   import match_logger_pkg::*;
#(
   parameter int TS_W = TS_W_DEF
) ();

   logic            out_valid;
   logic            out_ready;
   logic [TS_W-1:0] out_ts;

   modport master (output out_valid, output out_ts, input out_ready);
   modport slave  (input out_valid, input out_ts, output out_ready);

endinterface

// File: rtl/match_evt_fifo.sv
// First-word-fall-through synchronous FIFO: head entry is visible on rdata
// whenever the FIFO is non-empty, and rdata reads 0 while empty.
// Pointers wrap naturally because DEPTH is a power of two.
module match_evt_fifo
   import match_logger_pkg::*;
#(
   parameter  int W     = TS_W_DEF,
   parameter  int DEPTH = DEPTH_DEF,
   localparam int AW    = $clog2(DEPTH),
   localparam int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     wdata,
   output logic [W-1:0]     rdata,
   output logic [LVL_W-1:0] level,
   output logic             full,
   output logic             empty
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_pop;
   logic          do_push;

   assign empty   = (level == '0);
   assign full    = (level == LVL_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = empty ? '0 : mem[rd_ptr];

   // Storage write; only the pointers and level carry reset state.
   // NOTE: the data array is deliberately not reset -- empty/level already
   // mask stale contents, and leaving it unreset keeps it a plain RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointer and occupancy bookkeeping.
   // NOTE: non-blocking assignments so every register here samples the
   // pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/match_event_logger.sv
// Logs each detector match with a free-running cycle timestamp into a small
// FWFT FIFO drained over a valid/ready stream, and keeps a saturating match
// count plus a sticky overflow flag.
// Build option: MEL_DROP_CNT_EN adds the saturating dropped_count output.
module match_event_logger
   import match_logger_pkg::*;
#(
   parameter  int TS_W  = TS_W_DEF,
   parameter  int DEPTH = DEPTH_DEF,
   parameter  int CNT_W = CNT_W_DEF,
   localparam int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 match_in,
   input  logic                 clear,
   match_event_logger_if.master evt,
   output logic [LVL_W-1:0]     fifo_level,
   output logic [CNT_W-1:0]     match_count,
   output logic                 overflow
`ifdef MEL_DROP_CNT_EN
   ,
   output logic [CNT_W-1:0]     dropped_count
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [TS_W-1:0] ts_cnt;
   logic [TS_W-1:0] fifo_rdata;
   logic            fifo_full;
   logic            fifo_empty;
   logic            pop;
   logic            push;
   logic            drop;

   // Free-running timestamp; value before the edge tags that edge's event.
   always_ff @(posedge clk) begin
      if (reset) ts_cnt <= '0;
      else       ts_cnt <= ts_cnt + TS_W'(1);
   end

   // Decide per edge whether the head leaves and the new event is kept.
   // NOTE: every output gets a default first so no path leaves one unassigned
   // and no latch is inferred.
   always_comb begin
      pop  = 1'b0;
      push = 1'b0;
      drop = 1'b0;
      pop  = ~fifo_empty & evt.out_ready;
      drop = match_in & fifo_full & ~pop;
      push = match_in & ~drop;
   end

   match_evt_fifo #(
      .W     (TS_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (ts_cnt),
      .rdata (fifo_rdata),
      .level (fifo_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign evt.out_valid = ~fifo_empty;
   assign evt.out_ts    = fifo_rdata;

   // Total matches, dropped or not; a match coinciding with clear counts as 1.
   always_ff @(posedge clk) begin
      if (reset)         match_count <= '0;
      else if (clear)    match_count <= match_in ? CNT_W'(1) : '0;
      else if (match_in) match_count <= CNT_W'(sat_inc(32'(match_count), 32'(CNT_MAX)));
   end

   // Sticky loss flag; a drop in the clearing cycle still sets it.
   always_ff @(posedge clk) begin
      if (reset)      overflow <= 1'b0;
      else if (clear) overflow <= drop;
      else if (drop)  overflow <= 1'b1;
   end

`ifdef MEL_DROP_CNT_EN
   // Saturating count of events lost to a full FIFO.
   always_ff @(posedge clk) begin
      if (reset)      dropped_count <= '0;
      else if (clear) dropped_count <= drop ? CNT_W'(1) : '0;
      else if (drop)  dropped_count <= CNT_W'(sat_inc(32'(dropped_count), 32'(CNT_MAX)));
   end
`endif

endmodule

// File: tb/tb_match_event_logger.sv
// Bench for match_event_logger: a default build (TS_W=16, DEPTH=4, CNT_W=16)
// and a small build (TS_W=4, DEPTH=2, CNT_W=2) share one stimulus stream and
// are compared every cycle against a list-based reference model.
module tb_match_event_logger;
   import match_logger_pkg::*;

   localparam int NK = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic match_in = 1'b0;
   logic clear = 1'b0;

   always #5 clk = ~clk;

   match_event_logger_if #(.TS_W(16)) ia ();
   match_event_logger_if #(.TS_W(4))  ib ();

   logic [2:0]  lvl_a;
   logic [15:0] cnt_a;
   logic        ovf_a;
   logic [1:0]  lvl_b;
   logic [1:0]  cnt_b;
   logic        ovf_b;
`ifdef MEL_DROP_CNT_EN
   logic [15:0] drp_a;
   logic [1:0]  drp_b;
`endif

   match_event_logger #(.TS_W(16), .DEPTH(4), .CNT_W(16)) dut_a (
      .clk         (clk),
      .reset       (reset),
      .match_in    (match_in),
      .clear       (clear),
      .evt         (ia),
      .fifo_level  (lvl_a),
      .match_count (cnt_a),
      .overflow    (ovf_a)
`ifdef MEL_DROP_CNT_EN
      ,
      .dropped_count (drp_a)
`endif
   );

   match_event_logger #(.TS_W(4), .DEPTH(2), .CNT_W(2)) dut_b (
      .clk         (clk),
      .reset       (reset),
      .match_in    (match_in),
      .clear       (clear),
      .evt         (ib),
      .fifo_level  (lvl_b),
      .match_count (cnt_b),
      .overflow    (ovf_b)
`ifdef MEL_DROP_CNT_EN
      ,
      .dropped_count (drp_b)
`endif
   );

   // Reference model: per build, an ordered list of logged timestamps plus counters.
   int mq   [NK][8];
   int msz  [NK];
   int mcnt [NK];
   int mdrp [NK];
   bit movf [NK];
   int cyc;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic model_edge(input bit rst, input bit m, input bit r, input bit c);
      for (int k = 0; k < NK; k++) begin
         int depth;
         int tsmod;
         int cmax;
         bit pop;
         bit drop;
         depth = (k == 0) ? 4 : 2;
         tsmod = (k == 0) ? 65536 : 16;
         cmax  = (k == 0) ? 65535 : 3;
         if (rst) begin
            msz[k] = 0; mcnt[k] = 0; mdrp[k] = 0; movf[k] = 1'b0;
         end else begin
            pop  = (msz[k] > 0) && r;
            drop = m && (msz[k] == depth) && !pop;
            if (pop) begin
               for (int i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
               msz[k]--;
            end
            if (m && !drop) begin
               mq[k][msz[k]] = cyc % tsmod;
               msz[k]++;
            end
            if (c) begin
               mcnt[k] = m ? 1 : 0;
               mdrp[k] = drop ? 1 : 0;
               movf[k] = drop;
            end else begin
               if (m && mcnt[k] < cmax) mcnt[k]++;
               if (drop && mdrp[k] < cmax) mdrp[k]++;
               if (drop) movf[k] = 1'b1;
            end
         end
      end
      cyc = rst ? 0 : cyc + 1;
   endtask

   task automatic compare_all();
      check("a_valid", 32'(ia.out_valid), 32'(msz[0] > 0));
      check("a_ts",    32'(ia.out_ts),    32'((msz[0] > 0) ? mq[0][0] : 0));
      check("a_level", 32'(lvl_a),        32'(msz[0]));
      check("a_count", 32'(cnt_a),        32'(mcnt[0]));
      check("a_ovf",   32'(ovf_a),        32'(movf[0]));
      check("b_valid", 32'(ib.out_valid), 32'(msz[1] > 0));
      check("b_ts",    32'(ib.out_ts),    32'((msz[1] > 0) ? mq[1][0] : 0));
      check("b_level", 32'(lvl_b),        32'(msz[1]));
      check("b_count", 32'(cnt_b),        32'(mcnt[1]));
      check("b_ovf",   32'(ovf_b),        32'(movf[1]));
`ifdef MEL_DROP_CNT_EN
      check("a_drop",  32'(drp_a),        32'(mdrp[0]));
      check("b_drop",  32'(drp_b),        32'(mdrp[1]));
`endif
   endtask

   // One clock: drive at negedge, model the posedge, sample 1 ns later.
   task automatic step(input bit rst_v, input bit m, input bit r, input bit c);
      @(negedge clk);
      reset        = rst_v;
      match_in     = m;
      clear        = c;
      ia.out_ready = r;
      ib.out_ready = r;
      @(posedge clk);
      model_edge(rst_v, m, r, c);
      #1;
      compare_all();
   endtask

   initial begin
      ia.out_ready = 1'b0;
      ib.out_ready = 1'b0;
      cyc = 0;
      for (int k = 0; k < NK; k++) begin
         msz[k] = 0; mcnt[k] = 0; mdrp[k] = 0; movf[k] = 1'b0;
      end

      // Reset state
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      check("rst_valid", 32'(ia.out_valid), 32'd0);
      check("rst_ts",    32'(ia.out_ts),    32'd0);

      // Single match in the 3rd cycle after reset, consumer always ready
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      step(0, 1, 1, 0);
      check("t1_valid", 32'(ia.out_valid), 32'd1);
      check("t1_ts",    32'(ia.out_ts),    32'd2);
      check("t1_count", 32'(cnt_a),        32'd1);
      step(0, 0, 1, 0);
      check("t1_gone",  32'(ia.out_valid), 32'd0);

      // Five matches with a stalled consumer: fifth one is dropped
      step(1, 0, 0, 0);
      for (int t = 0; t < 10; t++) step(0, t[0], 0, 0);
      check("t2_level", 32'(lvl_a), 32'd4);
      check("t2_ovf",   32'(ovf_a), 32'd1);
      check("t2_count", 32'(cnt_a), 32'd5);
`ifdef MEL_DROP_CNT_EN
      check("t2_drop",  32'(drp_a), 32'd1);
`endif
      for (int i = 0; i < 4; i++) begin
         check("t2_drain", 32'(ia.out_ts), 32'(1 + 2 * i));
         step(0, 0, 1, 0);
      end

      // Full FIFO with simultaneous match and pop
      step(1, 0, 0, 0);
      for (int t = 0; t < 4; t++) step(0, 1, 0, 0);
      step(0, 1, 1, 0);
      check("t3_level", 32'(lvl_a), 32'd4);
      check("t3_ovf",   32'(ovf_a), 32'd0);
      for (int i = 0; i < 4; i++) begin
         check("t3_order", 32'(ia.out_ts), 32'(1 + i));
         step(0, 0, 1, 0);
      end

      // Timestamp wrap on the 4-bit build
      step(1, 0, 0, 0);
      for (int t = 0; t < 15; t++) step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      check("t5_ts15", 32'(ib.out_ts), 32'd15);
      check("t5_lvl",  32'(lvl_b),     32'd2);
      step(0, 0, 1, 0);
      check("t5_ts0",  32'(ib.out_ts), 32'd0);

      // Count saturation on the 2-bit build, then clear with a match
      step(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 1, 0);
         check("t4_sat", 32'(cnt_b), 32'((i < 3) ? i + 1 : 3));
      end
      step(0, 1, 1, 1);
      check("t4_clr_b", 32'(cnt_b), 32'd1);
      check("t4_clr_a", 32'(cnt_a), 32'd1);

      // Reset with events buffered
      step(1, 0, 0, 0);
      for (int t = 0; t < 3; t++) step(0, 1, 0, 0);
      check("t6_lvl3", 32'(lvl_a), 32'd3);
      step(1, 0, 0, 0);
      check("t6_valid", 32'(ia.out_valid), 32'd0);
      check("t6_lvl0",  32'(lvl_a),        32'd0);
      check("t6_ovf",   32'(ovf_a),        32'd0);
      step(0, 1, 1, 0);
      check("t6_ts0",   32'(ia.out_ts),    32'd0);

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         step(($urandom_range(63) == 0), 1'($urandom_range(1)),
              ($urandom_range(9) < 4), ($urandom_range(15) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
